// File: rtl/vga_timing_gen.sv
`timescale 1ns/1ps
// VGA raster timing: h/v counters with programmable porches, sync widths and polarity, plus decoded markers.
// Latency: decoded outputs are combinational from the counter registers, so they change on the same edge as the counters.
// Backpressure: none; pix_en low freezes all state and outputs, and restart returns to the origin on the next edge.
module vga_timing_gen #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter bit          H_POL    = 1'b0,
    parameter bit          V_POL    = 1'b0,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk_25MHz,
    input  logic             reset,
    input  logic             pix_en,
    input  logic             restart,
    output logic [CNT_W-1:0] h_count,
    output logic [CNT_W-1:0] v_count,
    output logic             hsync,
    output logic             vsync,
    output logic             video_on,
    output logic             line_start,
    output logic             frame_start,
    output logic             line_end
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    if (H_ACTIVE == 0 || H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
        V_ACTIVE == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0 || CNT_W == 0) begin : g_zero_width
        $error("vga_timing_gen: every width parameter must be non-zero");
    end

    if (64'(H_TOTAL) > (64'd1 << CNT_W) || 64'(V_TOTAL) > (64'd1 << CNT_W)) begin : g_cnt_too_narrow
        $error("vga_timing_gen: CNT_W too narrow for H_TOTAL/V_TOTAL");
    end

    // Every boundary is below the total, so these casts never drop set bits once the checks above hold.
    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_VIS    = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_VIS    = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_BEG   = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VS_BEG   = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

    always_ff @(posedge clk_25MHz or posedge reset) begin
        if (reset) begin
            h_count <= '0;
            v_count <= '0;
        end else if (restart) begin
            h_count <= '0;
            v_count <= '0;
        end else if (pix_en) begin
            if (h_count == H_LAST) begin
                h_count <= '0;
                v_count <= (v_count == V_LAST) ? '0 : v_count + 1'b1;
            end else begin
                h_count <= h_count + 1'b1;
            end
        end
    end

    assign hsync       = (h_count >= HS_BEG && h_count < HS_END) ? H_POL : ~H_POL;
    assign vsync       = (v_count >= VS_BEG && v_count < VS_END) ? V_POL : ~V_POL;
    assign video_on    = (h_count < H_VIS) && (v_count < V_VIS);
    assign line_start  = (h_count == '0);
    assign frame_start = (h_count == '0) && (v_count == '0);
    assign line_end    = (h_count == H_LAST);

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised VGA raster timing generator. Successor to the fixed 800-clock horizontal counter: one block now runs both axes, with programmable front porch, sync, back porch, active widths and sync polarity. It also adds a pixel-clock enable, a synchronous restart and frame/line markers. It sits between the pixel clock domain and the pixel/colour pipeline, which consumes `h_count`, `v_count` and `video_on`.

## Interface
- `H_ACTIVE`, 640: visible pixels per line
- `H_FP`, 16: horizontal front porch, clocks
- `H_SYNC`, 96: hsync pulse width, clocks
- `H_BP`, 48: horizontal back porch, clocks
- `V_ACTIVE`, 480: visible lines per frame
- `V_FP`, 10: vertical front porch, lines
- `V_SYNC`, 2: vsync pulse width, lines
- `V_BP`, 33: vertical back porch, lines
- `H_POL`, 0: hsync active level (0 = active-low)
- `V_POL`, 0: vsync active level (0 = active-low)
- `CNT_W`, 16: counter output width; must hold H_TOTAL-1 and V_TOTAL-1
- `clk_25MHz  in  1`: pixel clock
- `reset  in  1`: asynchronous, active-high
- `pix_en  in  1`: advance enable; counters hold when low
- `restart  in  1`: synchronous return to raster origin
- `h_count  out  CNT_W`: current column, 0..H_TOTAL-1
- `v_count  out  CNT_W`: current line, 0..V_TOTAL-1
- `hsync  out  1`: horizontal sync, polarity per H_POL
- `vsync  out  1`: vertical sync, polarity per V_POL
- `video_on  out  1`: high in the visible region
- `line_start  out  1`: high while h_count==0
- `frame_start  out  1`: high while h_count==0 and v_count==0
- `line_end  out  1`: high while h_count==H_TOTAL-1 (vertical advance strobe)

## Operation
- Derived values:
  - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (default 800).
  - V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (default 525).
- Region order on each axis: active, front porch, sync, back porch.
- Horizontal counter:
  - On a rising edge with pix_en=1, h_count increments.
  - At H_TOTAL-1 it wraps to 0.
- Vertical counter:
  - Advances only on an enabled edge where h_count==H_TOTAL-1.
  - At V_TOTAL-1 it wraps to 0, so both counters wrap together at the frame end.
- Decoded outputs are pure functions of the registered counters:
  - hsync = H_POL when H_ACTIVE+H_FP <= h_count < H_ACTIVE+H_FP+H_SYNC, else ~H_POL.
  - vsync = V_POL when V_ACTIVE+V_FP <= v_count < V_ACTIVE+V_FP+V_SYNC, else ~V_POL.
  - video_on = (h_count < H_ACTIVE) && (v_count < V_ACTIVE).
- Restart:
  - restart=1 at an edge sets both counters to 0, regardless of pix_en.
  - restart takes priority over increment and wrap.
- Priority order: reset > restart > pix_en increment.
- Counter arithmetic is unsigned, CNT_W bits. Comparisons use the full parameter values; no truncation is allowed.
- Elaboration fails on any of these:
  - any width parameter is zero;
  - H_TOTAL > 2^CNT_W or V_TOTAL > 2^CNT_W.

## Timing
- Reset (asynchronous, immediate):
  - h_count=0, v_count=0.
  - hsync=~H_POL, vsync=~V_POL.
  - video_on=1, line_start=1, frame_start=1, line_end=0.
- After reset deasserts, the first enabled edge moves h_count to 1.
- Output latency:
  - All outputs change on the same edge as the counters.
  - The decode adds zero cycles of latency relative to h_count/v_count.
- Period at pix_en=1:
  - One line = H_TOTAL clocks.
  - One frame = H_TOTAL*V_TOTAL clocks (420000 at defaults).
- pix_en=0: every output holds its value. Stretching the enable scales the periods; no state is lost.
- Reset mid-frame: counters return to 0 immediately. There is no partial-line carry.
- restart and pix_en=0 in the same cycle: counters are 0 after the edge.
- Back-to-back restart: counters stay at 0 and frame_start stays high.
- line_end is high for exactly one enabled cycle per line. On the last line, that same edge also wraps v_count to 0.

## Test plan
- Reset then free run at defaults:
  - h_count climbs 0..799 and wraps, with line_end high at 799.
  - v_count increments once per 800 clocks and wraps after 525 lines.
  - frame_start recurs every 420000 clocks.
- Horizontal sync at defaults:
  - hsync low for h_count 656..751 (96 clocks), high elsewhere.
  - video_on high for h 0..639 on lines 0..479 only.
- Vertical sync at defaults:
  - vsync low for v_count 490..491 (1600 clocks), high elsewhere.
  - video_on stays low on lines 480..524.
- pix_en toggling every other cycle:
  - Line length is 1600 clocks and hsync width is 192 clocks.
  - Counters hold on every cycle where pix_en=0.
- restart and reset mid-frame:
  - restart asserted at h=300, v=200 gives h=0, v=0 after the edge, with frame_start=1.
  - reset asserted asynchronously between edges drops the counters to 0 without waiting for a clock edge.
- Alternate parameter set: H 4/1/2/1, V 3/1/1/1, H_POL=1, V_POL=1.
  - H_TOTAL is 8, V_TOTAL is 6, and a frame is 48 clocks.
  - hsync is high at h 5..6 and vsync is high at v 4.
